// File: rtl/core_npc_pkg.sv
// Shared fetch-pipeline types: NPC state encoding, redirect bundle, reset vector default.
package core_npc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        IDLE = 2'd2
    } npc_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
    } redirect_t;

    localparam logic [31:0] RESET_VADDR_DEF = 32'h1c00_0000;

endpackage

// File: rtl/core_npc_seq.sv
// Sequential next-packet address and per-slot valid mask for a fetch PC; purely combinational.
// Shared with the branch predictor so both agree on packet alignment.
module core_npc_seq #(
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic [31:0]            pc,
    output logic [31:0]            seq,
    output logic [FETCH_WIDTH-1:0] mask
);

    localparam logic [31:0] PB_W  = 32'(4 * FETCH_WIDTH);
    localparam logic [31:0] ALIGN = ~(PB_W - 32'd1);
    localparam logic [31:0] SLOTM = 32'(FETCH_WIDTH - 1);

    logic [31:0] slot;

    // Realigning before the add also repairs misaligned redirect targets; wraps at 2^32.
    assign seq  = (pc & ALIGN) + PB_W;
    assign slot = (pc >> 2) & SLOTM;

    always_comb begin
        mask = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            mask[k] = (32'(k) >= slot);
        end
    end

endmodule

// File: rtl/core_npc.sv
// Fetch-PC generator: one packet address per cycle, redirects override sequential advance,
// npc_o exposes the pc register D input. Optional low-power IDLE state under CORE_NPC_IDLE_EN.
module core_npc
    import core_npc_pkg::*;
#(
    parameter logic [31:0] RESET_VADDR = RESET_VADDR_DEF,
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            pc_o,
    output logic                   valid_o,
    output logic [FETCH_WIDTH-1:0] mask_o,
    output logic [31:0]            npc_o,
    input  logic                   ready_i,
    input  logic                   f_stall_i,
    input  logic                   excp_redirect_i,
    input  logic [31:0]            excp_target_i,
    input  logic                   br_redirect_i,
    input  logic [31:0]            br_target_i
`ifdef CORE_NPC_IDLE_EN
    ,
    input  logic                   idle_i,
    input  logic                   wake_i
`endif
);

    npc_state_e  state, state_d;
    logic [31:0] pc, pc_d, seq;
    logic        fire;
    redirect_t   excp, br;

    assign excp = '{valid: excp_redirect_i, target: excp_target_i};
    assign br   = '{valid: br_redirect_i,   target: br_target_i};

    core_npc_seq #(.FETCH_WIDTH(FETCH_WIDTH)) u_seq (
        .pc   (pc),
        .seq  (seq),
        .mask (mask_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_VADDR;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            BOOT: state_d = RUN;
`ifdef CORE_NPC_IDLE_EN
            RUN:  if (idle_i && !excp.valid && !br.valid) state_d = IDLE;
            IDLE: if (wake_i || excp.valid || br.valid) state_d = RUN;
`endif
            default: state_d = state;
        endcase
    end

    assign valid_o = (state == RUN);
    assign fire    = valid_o & ready_i & ~f_stall_i;

    // Reset is folded in so npc_o matches what the register will actually hold.
    always_comb begin
        pc_d = pc;
        if (rst)             pc_d = RESET_VADDR;
        else if (excp.valid) pc_d = excp.target;
        else if (br.valid)   pc_d = br.target;
        else if (fire)       pc_d = seq;
    end

    assign pc_o  = pc;
    assign npc_o = pc_d;

endmodule

// File: tb/tb_core_npc.sv
// Directed self-checking bench for core_npc (FETCH_WIDTH=2); IDLE steps compiled in under CORE_NPC_IDLE_EN.
module tb_core_npc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_o, npc_o, excp_target_i, br_target_i;
    logic        valid_o, ready_i, f_stall_i, excp_redirect_i, br_redirect_i;
    logic [1:0]  mask_o;
`ifdef CORE_NPC_IDLE_EN
    logic        idle_i, wake_i;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    core_npc #(.RESET_VADDR(32'h1c00_0000), .FETCH_WIDTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_o            (pc_o),
        .valid_o         (valid_o),
        .mask_o          (mask_o),
        .npc_o           (npc_o),
        .ready_i         (ready_i),
        .f_stall_i       (f_stall_i),
        .excp_redirect_i (excp_redirect_i),
        .excp_target_i   (excp_target_i),
        .br_redirect_i   (br_redirect_i),
        .br_target_i     (br_target_i)
`ifdef CORE_NPC_IDLE_EN
        ,
        .idle_i          (idle_i),
        .wake_i          (wake_i)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic [1:0] m);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".pc"},    pc_o,         p);
        chk({tag, ".mask"},  32'(mask_o),  32'(m));
    endtask

    initial begin
        rst = 1'b1; ready_i = 1'b1; f_stall_i = 1'b0;
        excp_redirect_i = 1'b0; br_redirect_i = 1'b0;
        excp_target_i = '0; br_target_i = '0;
`ifdef CORE_NPC_IDLE_EN
        idle_i = 1'b0; wake_i = 1'b0;
`endif
        #12;
        chk_out("reset", 1'b0, 32'h1c00_0000, 2'b11);
        chk("reset.npc", npc_o, 32'h1c00_0000);
        rst = 1'b0;
        #1;
        chk("boot.npc_hold", npc_o, 32'h1c00_0000);
        step();
        chk_out("run0", 1'b1, 32'h1c00_0000, 2'b11);
        chk("run0.npc", npc_o, 32'h1c00_0008);
        step();
        chk_out("run1", 1'b1, 32'h1c00_0008, 2'b11);
        step();
        chk_out("run2", 1'b1, 32'h1c00_0010, 2'b11);

        f_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.npc", npc_o, 32'h1c00_0010);
            step();
            chk("stall.pc", pc_o, 32'h1c00_0010);
        end
        f_stall_i = 1'b0;
        step();
        chk("unstall.pc", pc_o, 32'h1c00_0018);

        ready_i = 1'b0;
        step();
        chk("notready.pc", pc_o, 32'h1c00_0018);
        ready_i = 1'b1;

        f_stall_i = 1'b1; br_redirect_i = 1'b1; br_target_i = 32'h1c00_0104;
        #1;
        chk("br.npc", npc_o, 32'h1c00_0104);
        step();
        chk_out("br", 1'b1, 32'h1c00_0104, 2'b10);
        br_redirect_i = 1'b0; f_stall_i = 1'b0;
        step();
        chk_out("br.seq", 1'b1, 32'h1c00_0108, 2'b11);

        excp_redirect_i = 1'b1; excp_target_i = 32'h1c00_8000;
        br_redirect_i = 1'b1;   br_target_i   = 32'h1c00_0200;
        step();
        chk("both.pc", pc_o, 32'h1c00_8000);
        br_redirect_i = 1'b0;
        excp_target_i = 32'hFFFF_FFF8;
        step();
        chk("excp.pc", pc_o, 32'hFFFF_FFF8);
        excp_redirect_i = 1'b0;
        #1;
        chk("wrap.npc", npc_o, 32'h0000_0000);
        step();
        chk("wrap.pc", pc_o, 32'h0000_0000);

        br_redirect_i = 1'b1; br_target_i = 32'h1c00_0002;
        step();
        chk_out("misalign", 1'b1, 32'h1c00_0002, 2'b11);
        br_redirect_i = 1'b0;
        step();
        chk("misalign.seq", pc_o, 32'h1c00_0008);

        // Redirect taken while still in BOOT
        rst = 1'b1;
        #1;
        chk_out("midrst", 1'b0, 32'h1c00_0000, 2'b11);
        step();
        rst = 1'b0;
        excp_redirect_i = 1'b1; excp_target_i = 32'h1c00_400c;
        #1;
        chk("bootredir.valid", 32'(valid_o), 32'd0);
        step();
        excp_redirect_i = 1'b0;
        chk_out("bootredir", 1'b1, 32'h1c00_400c, 2'b10);
        step();
        chk("bootredir.seq", pc_o, 32'h1c00_4010);

`ifdef CORE_NPC_IDLE_EN
        idle_i = 1'b1;
        step();
        idle_i = 1'b0;
        chk_out("idle", 1'b0, 32'h1c00_4018, 2'b11);
        for (int i = 0; i < 20; i++) step();
        chk_out("idle.hold", 1'b0, 32'h1c00_4018, 2'b11);
        wake_i = 1'b1;
        step();
        wake_i = 1'b0;
        chk_out("wake", 1'b1, 32'h1c00_4018, 2'b11);
        idle_i = 1'b1;
        step();
        idle_i = 1'b0;
        chk("idle2.valid", 32'(valid_o), 32'd0);
        rst = 1'b1;
        #1;
        chk_out("idle.rst", 1'b0, 32'h1c00_0000, 2'b11);
        step();
        rst = 1'b0;
        step();
        chk_out("idle.rst.run", 1'b1, 32'h1c00_0000, 2'b11);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
